// File: rtl/int_seq.sv
// Interrupt / reset entry sequencer for the 65C02 core.
// Takes over the bus for the reset, NMI, IRQ and BRK entry sequences.
// It pushes the return state, fetches the vector, then strobes the new PC, S and I.
//
// Bus handover with the main FSM:
//   - A request is accepted in IDLE. The request is BRK_REQ at any time, or INSTR_DONE
//     together with a pending NMI or an unmasked IRQ.
//   - From the next clock BUSY is 1, and the sequencer drives AB, DB_OUT and RW.
//   - SEQ_DONE (== PC_LOAD) is high for exactly one un-held cycle in FINISH.
//     The main FSM may fetch again on the cycle after it.
//   - HOLD freezes every non-IDLE state.
module int_seq #(
    parameter logic [15:0] NMI_VEC    = 16'hFFFA,
    parameter logic [15:0] RES_VEC    = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC    = 16'hFFFE,
    parameter logic [7:0]  STACK_PAGE = 8'h01
) (
    input  logic        PHI_0,
    input  logic        RST,
    input  logic        NMI,
    input  logic        IRQ,
    input  logic        HOLD,
    input  logic        INSTR_DONE,
    input  logic        BRK_REQ,
    input  logic        I_FLAG,
    input  logic [15:0] PC_IN,
    input  logic [7:0]  P_IN,
    input  logic [7:0]  S_IN,
    input  logic [7:0]  DB_IN,
    output logic [15:0] AB,
    output logic [7:0]  DB_OUT,
    output logic        RW,
    output logic        BUSY,
    output logic        PC_LOAD,
    output logic [15:0] PC_NEW,
    output logic        SP_LOAD,
    output logic [7:0]  SP_NEW,
    output logic        SET_I,
    output logic        SEQ_DONE,
    output logic [3:0]  DBG_STATE
);

    typedef enum logic [3:0] {
        IDLE, RST_D0, RST_D1, RST_D2, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, FINISH
    } state_t;

    typedef enum logic [1:0] {SRC_BRK, SRC_NMI, SRC_IRQ} src_t;

    state_t      state, next_state;
    src_t        src, start_src;
    logic [7:0]  sp;
    logic [15:0] ret;
    logic [15:0] vec;
    logic [7:0]  lo, hi;
    logic        nmi_prev, nmi_pend;

    // State register; reset always restarts the reset entry sequence
    always_ff @(posedge PHI_0 or posedge RST) begin
        if (RST) state <= RST_D0;
        else     state <= next_state;
    end

    // Next-state: request arbitration in IDLE, otherwise step unless held
    always_comb begin
        next_state = state;
        start_src  = SRC_IRQ;
        case (state)
            IDLE: begin
                if (BRK_REQ) begin
                    next_state = PUSH_PCH;
                    start_src  = SRC_BRK;
                end else if (INSTR_DONE && nmi_pend) begin
                    next_state = PUSH_PCH;
                    start_src  = SRC_NMI;
                end else if (INSTR_DONE && !IRQ && !I_FLAG) begin
                    next_state = PUSH_PCH;
                    start_src  = SRC_IRQ;
                end
            end
            RST_D0:   if (!HOLD) next_state = RST_D1;
            RST_D1:   if (!HOLD) next_state = RST_D2;
            RST_D2:   if (!HOLD) next_state = VEC_LO;
            PUSH_PCH: if (!HOLD) next_state = PUSH_PCL;
            PUSH_PCL: if (!HOLD) next_state = PUSH_P;
            PUSH_P:   if (!HOLD) next_state = VEC_LO;
            VEC_LO:   if (!HOLD) next_state = VEC_HI;
            VEC_HI:   if (!HOLD) next_state = FINISH;
            FINISH:   if (!HOLD) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Datapath: latch context on acceptance, walk the stack pointer, pick and read the vector
    always_ff @(posedge PHI_0 or posedge RST) begin
        if (RST) begin
            sp  <= 8'h00;
            ret <= 16'h0000;
            src <= SRC_IRQ;
            vec <= RES_VEC;
            lo  <= 8'h00;
            hi  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (next_state == PUSH_PCH) begin
                        sp  <= S_IN;
                        ret <= PC_IN;
                        src <= start_src;
                    end
                end
                RST_D0, RST_D1, PUSH_PCH, PUSH_PCL: if (!HOLD) sp <= sp - 8'd1;
                RST_D2: begin
                    if (!HOLD) begin
                        sp  <= sp - 8'd1;
                        vec <= RES_VEC;
                    end
                end
                PUSH_P: begin
                    if (!HOLD) begin
                        sp  <= sp - 8'd1;
                        // A pending NMI hijacks an IRQ/BRK entry at the last moment
                        vec <= (nmi_pend || src == SRC_NMI) ? NMI_VEC : IRQ_VEC;
                    end
                end
                VEC_LO:  if (!HOLD) lo <= DB_IN;
                VEC_HI:  if (!HOLD) hi <= DB_IN;
                default: ;
            endcase
        end
    end

    // NMI falling-edge detector; the request is consumed when its vector is committed
    always_ff @(posedge PHI_0 or posedge RST) begin
        if (RST) begin
            nmi_prev <= 1'b1;
            nmi_pend <= 1'b0;
        end else begin
            nmi_prev <= NMI;
            if (nmi_prev && !NMI)
                nmi_pend <= 1'b1;
            else if (state == PUSH_P && !HOLD && nmi_pend)
                nmi_pend <= 1'b0;
        end
    end

    // Outputs: bus cycle per state, completion strobes only in an un-held FINISH
    always_comb begin
        AB      = 16'h0000;
        DB_OUT  = 8'h00;
        RW      = 1'b1;
        BUSY    = 1'b1;
        PC_LOAD = 1'b0;
        PC_NEW  = 16'h0000;
        SP_LOAD = 1'b0;
        SP_NEW  = 8'h00;
        SET_I   = 1'b0;
        if (!RST) begin
            case (state)
                IDLE:                   BUSY = 1'b0;
                RST_D0, RST_D1, RST_D2: AB = {STACK_PAGE, sp};
                PUSH_PCH: begin
                    AB     = {STACK_PAGE, sp};
                    RW     = 1'b0;
                    DB_OUT = ret[15:8];
                end
                PUSH_PCL: begin
                    AB     = {STACK_PAGE, sp};
                    RW     = 1'b0;
                    DB_OUT = ret[7:0];
                end
                PUSH_P: begin
                    AB     = {STACK_PAGE, sp};
                    RW     = 1'b0;
                    DB_OUT = {P_IN[7:6], 1'b1, (src == SRC_BRK), P_IN[3:0]};
                end
                VEC_LO: AB = vec;
                VEC_HI: AB = vec + 16'd1;
                FINISH: begin
                    if (!HOLD) begin
                        PC_LOAD = 1'b1;
                        SP_LOAD = 1'b1;
                        SET_I   = 1'b1;
                        PC_NEW  = {hi, lo};
                        SP_NEW  = sp;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SEQ_DONE  = PC_LOAD;
    assign DBG_STATE = state;

endmodule

// File: doc/int_seq.md
Name: int_seq

Overview:
- Interrupt/reset sequencer for the 65C02 core.
- Owns the address bus, data-out and RW during the reset, NMI, IRQ and BRK entry sequences: stack pushes, vector fetch, PC/S/I-flag update.
- Main FSM hands the bus over at instruction boundaries (and on BRK) and waits for SEQ_DONE before the next FETCH.

Parameters:
- NMI_VEC, 16'hFFFA, NMI vector address (low byte; high byte at +1).
- RES_VEC, 16'hFFFC, reset vector address.
- IRQ_VEC, 16'hFFFE, IRQ/BRK vector address.
- STACK_PAGE, 8'h01, stack page high byte.

Ports:
- PHI_0  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- NMI  in  1  non-maskable interrupt, active low, edge-sensitive.
- IRQ  in  1  interrupt request, active low, level-sensitive.
- HOLD  in  1  1 = freeze the sequencer this cycle.
- INSTR_DONE  in  1  one-cycle pulse at an instruction boundary.
- BRK_REQ  in  1  one-cycle pulse from the decoder, BRK decoded.
- I_FLAG  in  1  current I status bit.
- PC_IN  in  16  return address to push.
- P_IN  in  8  current status register.
- S_IN  in  8  current stack pointer.
- DB_IN  in  8  data bus in.
- AB  out  16  address bus while BUSY.
- DB_OUT  out  8  data bus out.
- RW  out  1  1 = read, 0 = write.
- BUSY  out  1  sequencer owns the bus.
- PC_LOAD  out  1  one-cycle strobe: load PC_NEW.
- PC_NEW  out  16  vector fetched.
- SP_LOAD  out  1  one-cycle strobe, same cycle as PC_LOAD: load SP_NEW.
- SP_NEW  out  8  updated stack pointer.
- SET_I  out  1  one-cycle strobe, same cycle as PC_LOAD: set I.
- SEQ_DONE  out  1  equals PC_LOAD.

Behaviour:
- States: IDLE, RST_D0, RST_D1, RST_D2, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, FINISH.
- RST asserted (async):
  - state=RST_D0, sp=8'h00, nmi_pend=0.
  - AB=16'h0000, DB_OUT=8'h00, RW=1, BUSY=1, PC_LOAD=SP_LOAD=SET_I=SEQ_DONE=0, PC_NEW=0, SP_NEW=0.
  - Reset mid-sequence aborts it; no partial PC/SP load.
- NMI edge detect:
  - NMI registered every cycle.
  - Registered-1 then current-0 sets nmi_pend.
  - Cleared when VEC_LO is entered with NMI selected.
  - Held low = one request only.
- Start from IDLE (one clock later BUSY=1; latch sp<=S_IN and ret<=PC_IN in the same cycle):
  - BRK_REQ: src=BRK.
  - Else INSTR_DONE & nmi_pend: src=NMI.
  - Else INSTR_DONE & !IRQ & !I_FLAG: src=IRQ.
  - Else stay IDLE.
  - BRK_REQ and INSTR_DONE together: BRK wins; a pending NMI is taken via the hijack rule.
- RST_D0..D2:
  - Dummy stack reads, RW=1, AB={STACK_PAGE,sp}, sp decrements each cycle.
  - Then VEC_LO with vector RES_VEC.
- PUSH_PCH / PUSH_PCL / PUSH_P:
  - RW=0, AB={STACK_PAGE,sp}, sp decrements after each (8-bit wrap 00->FF).
  - DB_OUT: PUSH_PCH=ret[15:8], PUSH_PCL=ret[7:0], PUSH_P=P_IN with bit5=1 and bit4 (B)=1 for BRK, 0 for NMI/IRQ.
- Vector select at the PUSH_P->VEC_LO transition:
  - nmi_pend set (NMI hijack of IRQ/BRK): NMI_VEC.
  - Else BRK/IRQ: IRQ_VEC; NMI: NMI_VEC.
  - The pushed P keeps the original B bit.
- VEC_LO: RW=1, AB=vec, capture DB_IN into lo.
- VEC_HI: RW=1, AB=vec+1, capture DB_IN into hi.
- FINISH:
  - PC_LOAD=SP_LOAD=SET_I=SEQ_DONE=1 for one cycle, PC_NEW={hi,lo}, SP_NEW=sp.
  - Next state IDLE.
- IDLE outputs: BUSY=0, RW=1, AB=0, DB_OUT=0.
- HOLD=1 in any non-IDLE state: state, sp, AB, RW, DB_OUT frozen, no capture, no strobes. The FINISH strobes stay off until HOLD drops, then last exactly one cycle.
- HOLD has no effect in IDLE; requests are still accepted.
- Latency:
  - IRQ/NMI/BRK: 7 clocks from request to SEQ_DONE (start + 3 push + 2 vec + finish), excluding HOLD.
  - Reset: 6 clocks after RST deassert to SEQ_DONE.
- IRQ deasserting after acceptance does not abort. I_FLAG is sampled only at acceptance.
- NMI edge during FINISH or IDLE with no INSTR_DONE: stays pending until the next boundary.

Test Plan:
- Reset: RST pulse, S_IN ignored, mem[FFFC]=34, mem[FFFD]=12 -> reads at 0100,01FF,01FE then FFFC,FFFD; PC_NEW=1234, SP_NEW=FD, SET_I=1, no writes.
- IRQ: S_IN=FF, PC_IN=C123, P_IN=0x81, I_FLAG=0, IRQ=0, INSTR_DONE -> writes 01FF=C1, 01FE=23, 01FD=A1; reads FFFE/FFFF; SP_NEW=FC.
- Masked IRQ: I_FLAG=1, IRQ=0, INSTR_DONE -> BUSY stays 0, no bus activity.
- BRK with NMI hijack: BRK_REQ, P_IN=0x00, NMI falls during PUSH_PCL -> P pushed 0x30, vector read from FFFA/FFFB, nmi_pend cleared, NMI held low does not retrigger.
- Stack wrap + HOLD: S_IN=01, HOLD=1 for 3 cycles during PUSH_PCL -> pushes at 0101,0100,01FF, AB/DB_OUT stable during hold, SP_NEW=FE, total 10 clocks.
- Reset mid-sequence: RST asserted during VEC_LO of IRQ -> no PC_LOAD, full reset sequence follows, PC_NEW from FFFC.
